// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
// audio_pkg
// Shared types and helpers for the audio mixer / delta-sigma block.
//   mix_mode_e  : output mode encodings (PCM, DSM1, DSM2, reserved)
//   mix_state_e : mixer FSM states
//   GAIN_UNITY  : gain code that represents x1.0
//   FRAC_SH     : fractional bits of the gain (log2 of GAIN_UNITY)
//   sat_s()     : clamp a signed value into a signed field of 'width' bits
package audio_pkg;

  typedef enum logic [1:0] {
    MIX_PCM  = 2'd0,
    MIX_DSM1 = 2'd1,
    MIX_DSM2 = 2'd2,
    MIX_RSVD = 2'd3
  } mix_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_e;

  localparam int GAIN_UNITY = 8;
  localparam int FRAC_SH    = $clog2(GAIN_UNITY);

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                              input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/audio_mix_dsm_if.sv
`timescale 1ns/1ps
// audio_mix_dsm_if
// Bundles the mixer's sample inputs, configuration and outputs.
//   master : sound-source side (drives samples, strobe, gains, mode)
//   slave  : the mixer (drives pcm_out/pcm_valid/dsm_out/busy/clip/overrun)
interface audio_mix_dsm_if #(
  parameter int CHANNELS = 5,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 4
);
  logic                       sample_ce;
  logic [CHANNELS*IN_W-1:0]   ch_data;
  logic [CHANNELS-1:0]        ch_signed;
  logic [CHANNELS*GAIN_W-1:0] ch_gain;
  logic [CHANNELS-1:0]        ch_mute;
  logic [1:0]                 mode;
  logic signed [OUT_W-1:0]    pcm_out;
  logic                       pcm_valid;
  logic                       dsm_out;
  logic                       busy;
  logic                       clip;
  logic                       overrun;

  modport master (
    output sample_ce, ch_data, ch_signed, ch_gain, ch_mute, mode,
    input  pcm_out, pcm_valid, dsm_out, busy, clip, overrun
  );

  modport slave (
    input  sample_ce, ch_data, ch_signed, ch_gain, ch_mute, mode,
    output pcm_out, pcm_valid, dsm_out, busy, clip, overrun
  );
endinterface

// File: rtl/audio_dsm.sv
`timescale 1ns/1ps
// audio_dsm
// 1st/2nd-order delta-sigma modulator fed by the mixed PCM sample.
//   clk_sys : system clock
//   reset   : synchronous, active-high
//   mode    : MIX_DSM1 / MIX_DSM2 run the modulator; other codes hold it at 0
//   pcm_out : signed PCM sample from the mixer
//   dsm_out : registered 1-bit stream
module audio_dsm
  import audio_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic signed [OUT_W-1:0] pcm_out,
  output logic                    dsm_out
);
  localparam int INT_W  = OUT_W + 4;
  localparam int WIDE_W = OUT_W + 6;  // headroom for integrator + two addends
  localparam logic signed [WIDE_W-1:0] FB  = WIDE_W'(64'sd1 <<< (OUT_W - 1));
  localparam logic signed [WIDE_W-1:0] LIM = WIDE_W'(64'sd1 <<< (OUT_W + 2));

  function automatic logic signed [INT_W-1:0] clamp(input logic signed [WIDE_W-1:0] v);
    if (v > LIM)  return INT_W'(LIM);
    if (v < -LIM) return INT_W'(-LIM);
    return INT_W'(v);
  endfunction

  logic [OUT_W:0]             acc1_q, acc1_d, acc1_sum;
  logic signed [INT_W-1:0]    i1_q, i1_d, i1_new;
  logic signed [INT_W-1:0]    i2_q, i2_d, i2_new;
  logic [1:0]                 mode_q, mode_d;
  logic                       dsm_out_q, dsm_out_d;
  logic [OUT_W-1:0]           u;
  logic signed [WIDE_W-1:0]   f;

  always_comb begin
    u        = {~pcm_out[OUT_W-1], pcm_out[OUT_W-2:0]};
    f        = dsm_out_q ? FB : -FB;
    acc1_sum = {1'b0, acc1_q[OUT_W-1:0]} + {1'b0, u};
    // i2 integrates the freshly updated i1 (same-cycle cascade).
    i1_new   = clamp(WIDE_W'(i1_q) + WIDE_W'(pcm_out) - f);
    i2_new   = clamp(WIDE_W'(i2_q) + WIDE_W'(i1_new) - f);

    mode_d    = mode;
    acc1_d    = '0;
    i1_d      = '0;
    i2_d      = '0;
    dsm_out_d = 1'b0;
    // A mode change leaves everything at the zero defaults for one clock.
    if (mode == mode_q) begin
      case (mix_mode_e'(mode))
        MIX_DSM1: begin
          acc1_d    = acc1_sum;
          dsm_out_d = acc1_sum[OUT_W];
        end
        MIX_DSM2: begin
          i1_d      = i1_new;
          i2_d      = i2_new;
          dsm_out_d = ~i2_new[INT_W-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc1_q    <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      mode_q    <= MIX_PCM;
      dsm_out_q <= 1'b0;
    end else begin
      acc1_q    <= acc1_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      mode_q    <= mode_d;
      dsm_out_q <= dsm_out_d;
    end
  end

  assign dsm_out = dsm_out_q;
endmodule

// File: rtl/audio_mix_dsm.sv
`timescale 1ns/1ps
// audio_mix_dsm
// N-channel mixer: per-channel signedness, gain (1/8 units) and mute, one
// channel accumulated per clock, saturating PCM output, optional DSM stream.
//   clk_sys : system clock
//   reset   : synchronous, active-high
//   mix     : slave side of audio_mix_dsm_if (samples, config, results)
module audio_mix_dsm
  import audio_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 4
) (
  input  logic           clk_sys,
  input  logic           reset,
  audio_mix_dsm_if.slave mix
);
  localparam int PROD_W = IN_W + GAIN_W;
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Remove the gain fraction, then any extra input precision.
  localparam int SHIFT  = FRAC_SH + ((IN_W > OUT_W) ? (IN_W - OUT_W) : 0);

  mix_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [CHANNELS*IN_W-1:0]    data_q, data_d;
  logic [CHANNELS-1:0]         signed_q, signed_d;
  logic [CHANNELS*GAIN_W-1:0]  gain_q, gain_d;
  logic [CHANNELS-1:0]         mute_q, mute_d;
  logic signed [OUT_W-1:0]     pcm_q, pcm_d;
  logic                        clip_q, clip_d;
  logic                        overrun_q, overrun_d;

  int                          ch;
  logic [IN_W-1:0]             raw;
  logic signed [IN_W-1:0]      sval;
  logic [GAIN_W-1:0]           gain;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     sum;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [63:0]          sat_v;
  logic                        clip_hit;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ch   = int'(idx_q);
    raw  = data_q[ch*IN_W +: IN_W];
    sval = signed_q[ch] ? raw : {~raw[IN_W-1], raw[IN_W-2:0]};
    gain = gain_q[ch*GAIN_W +: GAIN_W];

    // Shift-add multiply by the unsigned gain; a muted channel adds nothing.
    prod = '0;
    if (!mute_q[ch]) begin
      for (int b = 0; b < GAIN_W; b++) begin
        if (gain[b]) prod = prod + (PROD_W'(sval) <<< b);
      end
    end

    sum      = acc_q + ACC_W'(prod);
    shifted  = sum >>> SHIFT;  // arithmetic: truncates toward -inf
    sat_v    = sat_s(64'(shifted), OUT_W);
    clip_hit = (sat_v != 64'(shifted));

    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    data_d    = data_q;
    signed_d  = signed_q;
    gain_d    = gain_q;
    mute_d    = mute_q;
    pcm_d     = pcm_q;
    clip_d    = clip_q;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mix.sample_ce) begin
          state_d  = ST_SUM;
          idx_d    = '0;
          acc_d    = '0;
          data_d   = mix.ch_data;
          signed_d = mix.ch_signed;
          gain_d   = mix.ch_gain;
          mute_d   = mix.ch_mute;
        end
      end
      ST_SUM: begin
        if (mix.sample_ce) overrun_d = 1'b1;
        acc_d = sum;
        if (idx_q == IDX_W'(CHANNELS - 1)) begin
          // Result is registered on entry to OUT so pcm_out and pcm_valid
          // appear together in the OUT cycle.
          state_d = ST_OUT;
          pcm_d   = sat_v[OUT_W-1:0];
          clip_d  = clip_q | clip_hit;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_OUT: begin
        if (mix.sample_ce) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      pcm_q     <= '0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      pcm_q     <= pcm_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the snapshot registers carry no reset; they are always loaded on
  // the strobe edge before the FSM reads them, so a reset would be dead logic.
  always_ff @(posedge clk_sys) begin
    data_q   <= data_d;
    signed_q <= signed_d;
    gain_q   <= gain_d;
    mute_q   <= mute_d;
  end

  audio_dsm #(.OUT_W(OUT_W)) u_dsm (
    .clk_sys (clk_sys),
    .reset   (reset),
    .mode    (mix.mode),
    .pcm_out (pcm_q),
    .dsm_out (mix.dsm_out)
  );

  assign mix.pcm_out   = pcm_q;
  assign mix.pcm_valid = (state_q == ST_OUT);
  assign mix.busy      = (state_q != ST_IDLE);
  assign mix.clip      = clip_q;
  assign mix.overrun   = overrun_q;
endmodule

// File: tb/tb_audio_mix_dsm.sv
`timescale 1ns/1ps
// tb_audio_mix_dsm
// Directed stimulus for audio_mix_dsm; expected mixes go into a scoreboard
// queue and a negedge monitor pops and compares on every pcm_valid.
module tb_audio_mix_dsm;
  import audio_pkg::*;

  localparam int CH = 5;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int GW = 4;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  audio_mix_dsm_if #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)) mif ();

  audio_mix_dsm #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .mix     (mif)
  );

  typedef struct {
    int pcm;
    bit clip;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp,
                       input longint tol = 0);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d",
               name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: every pcm_valid must match the oldest pending expectation.
  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (mif.pcm_valid === 1'b1) begin
      check("valid_has_pending_entry", (sb.size() != 0) ? 1 : 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pcm_out", longint'($signed(mif.pcm_out)), e.pcm);
        check("clip_at_valid", mif.clip, e.clip);
        check("valid_latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic set_ch(input int k, input int d, input bit sgn, input int g, input bit m);
    mif.ch_data[k*IW +: IW]  = IW'(d);
    mif.ch_signed[k]         = sgn;
    mif.ch_gain[k*GW +: GW]  = GW'(g);
    mif.ch_mute[k]           = m;
  endtask

  task automatic mute_all();
    for (int k = 0; k < CH; k++) set_ch(k, 0, 1'b1, 8, 1'b1);
  endtask

  task automatic cfg_basic();
    set_ch(0, 1000, 1'b1, 8, 1'b0);
    set_ch(1, 2000, 1'b1, 8, 1'b0);
    set_ch(2, -500, 1'b1, 8, 1'b0);
    set_ch(3, 0,    1'b1, 8, 1'b0);
    set_ch(4, 0,    1'b1, 8, 1'b0);
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // One-cycle strobe in cycle 'at'; optionally queue its expected result.
  task automatic strobe(input int at, input bit expect_out, input int exp_pcm,
                        input bit exp_clip, output int t);
    goto_cycle(at);
    t = cyc;
    mif.sample_ce = 1'b1;
    if (expect_out) sb.push_back('{exp_pcm, exp_clip, t + CH + 1});
    @(posedge clk_sys);
    #1;
    mif.sample_ce = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic mix(input int exp_pcm, input bit exp_clip);
    int t;
    strobe(cyc + 1, 1'b1, exp_pcm, exp_clip, t);
    check("busy_after_strobe", mif.busy, 1);
    drain();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (mif.dsm_out === 1'b1) ones++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int t0, t1, t2, tx, ones;
    reset         = 1'b1;
    mif.sample_ce = 1'b0;
    mif.mode      = MIX_PCM;
    mif.ch_data   = '0;
    mif.ch_signed = '1;
    mif.ch_gain   = '0;
    mif.ch_mute   = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk_sys);
    check("rst_pcm_out", longint'($signed(mif.pcm_out)), 0);
    check("rst_pcm_valid", mif.pcm_valid, 0);
    check("rst_dsm_out", mif.dsm_out, 0);
    check("rst_busy", mif.busy, 0);
    check("rst_clip", mif.clip, 0);
    check("rst_overrun", mif.overrun, 0);

    // Basic signed mix: (1000+2000-500) at unity gain
    cfg_basic();
    mix(2500, 1'b0);

    // Mixed gains, an unsigned source and a muted source:
    // 1000*4 - 800*12 + 4096*15 = 55840 -> /8 = 6980
    set_ch(0, 1000,    1'b1, 4,  1'b0);
    set_ch(1, -800,    1'b1, 12, 1'b0);
    set_ch(2, 'h9000,  1'b0, 15, 1'b0);
    set_ch(3, 5000,    1'b1, 8,  1'b1);
    set_ch(4, 0,       1'b1, 0,  1'b0);
    mix(6980, 1'b0);

    // -3 * 1 / 8 truncates toward -inf
    mute_all();
    set_ch(0, -3, 1'b1, 1, 1'b0);
    mix(-1, 1'b0);

    // Offset-binary midscale and full scale
    mute_all();
    set_ch(0, 'h8000, 1'b0, 8, 1'b0);
    mix(0, 1'b0);
    set_ch(0, 'hFFFF, 1'b0, 8, 1'b0);
    mix(32767, 1'b0);

    // Saturation both ways; clip is sticky
    for (int k = 0; k < CH; k++) set_ch(k, 32767, 1'b1, 15, 1'b0);
    mix(32767, 1'b1);
    for (int k = 0; k < CH; k++) set_ch(k, -32768, 1'b1, 15, 1'b0);
    mix(-32768, 1'b1);
    cfg_basic();
    mix(2500, 1'b1);
    pulse_reset();
    check("clip_cleared_by_reset", mif.clip, 0);

    // Overrun: strobe at T+3 ignored, strobe at T+7 accepted
    strobe(cyc + 1, 1'b1, 2500, 1'b0, t0);
    check("overrun_before_second_strobe", mif.overrun, 0);
    strobe(t0 + 3, 1'b0, 0, 1'b0, tx);
    check("overrun_set", mif.overrun, 1);
    check("busy_during_mix", mif.busy, 1);
    strobe(t0 + 7, 1'b1, 2500, 1'b0, t1);
    check("busy_after_t7_strobe", mif.busy, 1);
    drain();
    check("overrun_sticky", mif.overrun, 1);

    // Reset in the middle of a mix
    strobe(cyc + 1, 1'b0, 0, 1'b0, t2);
    goto_cycle(t2 + 3);
    pulse_reset();
    check("midrst_pcm_out", longint'($signed(mif.pcm_out)), 0);
    check("midrst_pcm_valid", mif.pcm_valid, 0);
    check("midrst_busy", mif.busy, 0);
    check("midrst_overrun", mif.overrun, 0);
    check("midrst_clip", mif.clip, 0);
    check("midrst_dsm_out", mif.dsm_out, 0);
    goto_cycle(t2 + 12);
    mix(2500, 1'b0);

    // DSM1 with pcm_out = 0 -> exactly alternating
    mute_all();
    set_ch(0, 'h8000, 1'b0, 8, 1'b0);
    mix(0, 1'b0);
    mif.mode = MIX_DSM1;
    repeat (16) @(negedge clk_sys);
    count_ones(1024, ones);
    check("dsm1_ones_of_1024", ones, 512, 1);

    // DSM2 with pcm_out = 16384 -> 75% density
    set_ch(0, 16384, 1'b1, 8, 1'b0);
    mix(16384, 1'b0);
    mif.mode = MIX_DSM2;
    repeat (64) @(negedge clk_sys);
    count_ones(1024, ones);
    check("dsm2_ones_of_1024", ones, 768, 10);

    // Back to PCM mode: stream held at 0
    mif.mode = MIX_PCM;
    repeat (2) @(negedge clk_sys);
    count_ones(32, ones);
    check("pcm_mode_dsm_ones", ones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_mix_dsm.md
# audio_mix_dsm

Parametrised N-channel audio mixer with per-channel gain, mute and signedness, a saturating sum stage, and a selectable PCM / 1st-order / 2nd-order delta-sigma output. It generalises the fixed 4-source 1-bit PWM accumulator used in arcade cores. It sits between a core's sound sources (DAC latches, speech, FM) and the `AUDIO_L`/`AUDIO_R` outputs, with one instance per output channel. It runs on the core's system clock with a sample strobe.

## Interface

Parameters:
- `CHANNELS`, default 5: number of input sources, 1..16.
- `IN_W`, default 16: per-channel input width; narrower sources are left-justified by the instantiator.
- `OUT_W`, default 16: PCM output width; must be ≤ `IN_W`+4.
- `GAIN_W`, default 4: gain field width; gain is unsigned in 1/8 units (0 → ×0, 8 → ×1, 15 → ×1.875).

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `sample_ce` in 1: one-cycle strobe that starts a mix.
- `ch_data` in `CHANNELS*IN_W`: packed samples; channel k is at bits `[k*IN_W +: IN_W]`.
- `ch_signed` in `CHANNELS`: 1 = two's complement, 0 = offset-binary unsigned.
- `ch_gain` in `CHANNELS*GAIN_W`: packed per-channel gain.
- `ch_mute` in `CHANNELS`: 1 forces the channel's contribution to 0.
- `mode` in 2: 0 = PCM only, 1 = DSM 1st order, 2 = DSM 2nd order, 3 = reserved (behaves as 0).
- `pcm_out` out `OUT_W`: signed mixed sample.
- `pcm_valid` out 1: one-cycle pulse when `pcm_out` updates.
- `dsm_out` out 1: delta-sigma bitstream, updated every clock.
- `busy` out 1: mix in progress.
- `clip` out 1: sticky; set on saturation, cleared by `reset` only.
- `overrun` out 1: sticky; set when `sample_ce` arrives while `busy`.

## Operation

- FSM states: IDLE, SUM, OUT.
  - IDLE → SUM on `sample_ce`. On the same edge, snapshot `ch_data`, `ch_signed`, `ch_gain` and `ch_mute` into registers. Clear the accumulator and set channel index to 0.
  - SUM: process one channel per cycle.
    - Convert to signed: if `ch_signed`=0, invert the MSB.
    - Multiply by gain using shift-add, giving an `IN_W+GAIN_W`-bit signed product.
    - Add the product to a signed accumulator of width `ACC_W = IN_W+GAIN_W+clog2(CHANNELS)`. This width cannot overflow.
    - A muted channel or gain 0 adds 0.
    - After index `CHANNELS-1`, go to OUT.
  - OUT: compute `acc >>> 3` (arithmetic shift) and align it to `OUT_W`:
    - If `IN_W > OUT_W`, drop `IN_W-OUT_W` further LSBs (truncate toward −∞).
    - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - Register the result to `pcm_out`, pulse `pcm_valid`, set `clip` if saturation occurred, then return to IDLE.
- `sample_ce` in SUM or OUT is ignored and sets `overrun`. The running mix is unaffected.
- DSM input is `u = pcm_out` with its MSB inverted (unsigned).
- 1st-order DSM: `acc1` is `OUT_W+1` bits. Each clock, `acc1 <= {0, acc1[OUT_W-1:0]} + u`, and `dsm_out = acc1[OUT_W]` (registered).
- 2nd-order DSM:
  - Integrators `i1` and `i2` are signed, `OUT_W+4` bits.
  - Feedback `f = dsm_out ? +2^(OUT_W−1) : −2^(OUT_W−1)`.
  - Each clock: `i1 += pcm_out − f`, then `i2 += i1 − f`. Each integrator saturates at ±2^(OUT_W+2).
  - `dsm_out <= ~i2[MSB]`.
- Mode 0 or 3: `dsm_out` is 0 and the DSM state is held at zero.
- Any change of `mode` clears `acc1`, `i1` and `i2` on the following clock.

## Timing

- Reset values:
  - State IDLE; accumulator and index 0.
  - `pcm_out` 0, `pcm_valid` 0, `dsm_out` 0, `busy` 0, `clip` 0, `overrun` 0.
  - `acc1`, `i1`, `i2` all 0.
- Latency: with `sample_ce` at cycle T, `pcm_valid`=1 at cycle T+`CHANNELS`+1. `pcm_out` is valid from that cycle and holds until the next update.
- `busy` is 1 from T+1 through the `pcm_valid` cycle inclusive.
- Minimum `sample_ce` spacing without overrun is `CHANNELS`+2 cycles. A strobe in the cycle after `pcm_valid` is accepted.
- The DSM sees a new `pcm_out` on the cycle after `pcm_valid`.
- `reset` mid-mix abandons the mix. No `pcm_valid` is produced and the sticky flags are cleared.
- Inputs may change freely after the snapshot edge.

## Structure

- Shared package `audio_pkg`:
  - `mode` encodings `MIX_PCM`, `MIX_DSM1`, `MIX_DSM2`.
  - FSM state enum.
  - `GAIN_UNITY` = 8.
  - Function `sat_s(value, width)`.
- Sub-module `audio_dsm` contains the 1st/2nd-order modulator: inputs `clk_sys`, `reset`, `mode`, `pcm_out`; output `dsm_out`.

## Test plan

- `CHANNELS`=5, `IN_W`=`OUT_W`=16, all gains 8, all signed, inputs {1000, 2000, −500, 0, 0}, `sample_ce` at T → `pcm_out`=2500 and `pcm_valid` at T+6, `clip`=0.
- Unsigned channel 0 = 0x8000, others muted, gain 8 → `pcm_out`=0. Then input 0xFFFF → `pcm_out`=32767.
- All five channels 32767 at gain 15 → `pcm_out`=32767, `clip`=1 and stays 1 until `reset`. All −32768 at gain 15 → `pcm_out`=−32768.
- `sample_ce` at T and T+3 → the second strobe is ignored, `overrun`=1, a single `pcm_valid` at T+6. A strobe at T+7 is accepted.
- Mode 1 with `pcm_out`=0 → `dsm_out` density 50% (512 ±1 ones over 1024 clocks). Mode 2 with `pcm_out`=16384 → density 75% ±1%.
- `reset` asserted at T+3 of a mix → no `pcm_valid`, all outputs 0 on the next cycle. A new `sample_ce` mixes normally.
